parity_tally: RTL
=================

# parity_tally

Frame-based statistics stage that sits directly downstream of the `odd_even` classifier and consumes its `even`/`odd` flags one sample at a time. It counts even, odd and illegal (flags not mutually exclusive) samples over fixed frames of `FRAME_LEN` accepted samples. It also tracks the longest run of consecutive same-parity samples in each frame. Per-frame results are registered and held, and a `frame_done` pulse marks each update.

## Interface
Parameters:
- `FRAME_LEN`, default 10: accepted samples per frame; legal range 2..255.
- `CNT_W`, derived localparam `$clog2(FRAME_LEN+1)`: width of all count outputs.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: leaves IDLE and begins counting; ignored in other states.
- `clear` input 1: synchronous abort back to IDLE.
- `in_valid` input 1: a sample is present on `even`/`odd`.
- `even` input 1: even flag from the classifier.
- `odd` input 1: odd flag from the classifier.
- `in_ready` output 1: high only in COUNT.
- `even_count` output CNT_W: even samples in the last completed frame.
- `odd_count` output CNT_W: odd samples in the last completed frame.
- `err_count` output CNT_W: samples with `even==odd` in the last completed frame.
- `max_run` output CNT_W: longest same-parity run in the last completed frame.
- `frame_done` output 1: one-cycle pulse when the result outputs update.
- `busy` output 1: high in COUNT and REPORT.

## Operation
- States:
  - IDLE: reset state.
  - COUNT: accepting samples.
  - REPORT: one cycle; `in_ready` is low.
- State transitions:
  - IDLE→COUNT on `start`.
  - COUNT→REPORT on acceptance of the FRAME_LEN-th sample.
  - REPORT→COUNT unconditionally, so framing is free-running.
  - Any state→IDLE on `clear`.
- Acceptance is `in_valid & in_ready`. Samples presented while `in_ready` is low are dropped and never counted.
- Sample classification:
  - `even=1,odd=0` → even.
  - `even=0,odd=1` → odd.
  - `even==odd` → error.
  - Every accepted sample, error samples included, advances the frame sample counter.
- Run tracking uses internal `run_len` and `last_par`:
  - A legal sample with parity equal to `last_par`, where the previous accepted sample was legal, gives `run_len+1`.
  - Any other legal sample gives `run_len=1`.
  - An error sample gives `run_len=0`.
  - `max_run_int` holds the maximum `run_len` seen in the frame.
- Internal counters saturate at `FRAME_LEN`. They cannot overflow by construction because the frame ends at `FRAME_LEN`.
- On entering REPORT:
  - The result outputs load the internal values, including the final sample.
  - The internal counters, `run_len` and `max_run_int` clear to 0.
- The result outputs hold their value until the next REPORT. `clear` and `start` do not alter them.
- `clear`:
  - Zeroes the internal counters and the run state.
  - Discards any sample accepted in the same cycle.
  - Takes priority over frame completion: no REPORT occurs and no `frame_done` pulse is issued.
- `rst_n` low zeroes all outputs and internal state and forces IDLE. Reset has priority over `clear` and `start`.

## Timing
- Reset values: `in_ready=0`, `busy=0`, `frame_done=0`, all counts=0, state IDLE.
- `start` sampled at edge N → `in_ready=1` from cycle N+1.
- The FRAME_LEN-th accept at edge N → `frame_done=1` and new results visible in cycle N+1 → `in_ready` returns to 1 in cycle N+2. Latency from the last sample to results is 1 cycle.
- Sustained throughput: FRAME_LEN samples per FRAME_LEN+1 cycles.
- `frame_done` is never high for 2 consecutive cycles.
- Gaps in `in_valid` stall the frame without penalty. Partial-frame state persists indefinitely.
- Reset asserted mid-frame: partial counts are lost. No `frame_done` is issued.

## Test plan
- FRAME_LEN=10, drive the classifier with num 0..9 back-to-back → one `frame_done` 1 cycle after the 10th accept; `even_count=5`, `odd_count=5`, `err_count=0`, `max_run=1`.
- Samples E,E,E,O,O,X(`even=odd=1`),E,E,E,E → `even_count=7`, `odd_count=2`, `err_count=1`, `max_run=4`.
- Hold `in_valid=1` continuously for 25 samples → 2 `frame_done` pulses spaced 11 cycles apart; `in_ready` low exactly on the pulse cycles; the samples offered in those cycles are not counted.
- Assert `clear` together with the 10th accept → no `frame_done`, state IDLE, outputs keep the previous frame's values; `start` then a fresh 10 samples give correct counts.
- Assert `rst_n=0` mid-frame with `start`/`clear` also high → next cycle all outputs 0, IDLE, `in_ready=0`.
- Before `start`, apply `in_valid` with 5 samples → `in_ready=0`, no counting; after `start`, the counts reflect only later samples.

Source files
------------

// File: rtl/parity_tally_if.sv
// Sample handshake between the odd_even classifier and parity_tally.
// The classifier side is the master; the tally stage is the slave.
interface parity_tally_if;
    logic in_valid;
    logic even;
    logic odd;
    logic in_ready;

    modport master (
        output in_valid,
        output even,
        output odd,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  even,
        input  odd,
        output in_ready
    );
endinterface

// File: rtl/parity_tally.sv
// Frame statistics over classifier flags: even/odd/illegal counts and the
// longest same-parity run, reported once per FRAME_LEN accepted samples.
module parity_tally #(
    parameter  int FRAME_LEN = 10,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    parity_tally_if.slave        smp,
    output logic [CNT_W-1:0]     even_count,
    output logic [CNT_W-1:0]     odd_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     max_run,
    output logic                 frame_done,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REPORT
    } state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] even_cnt;
    logic [CNT_W-1:0] odd_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] max_run_int;
    logic             last_par;

    logic [CNT_W-1:0] even_nxt;
    logic [CNT_W-1:0] odd_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic [CNT_W-1:0] run_nxt;
    logic [CNT_W-1:0] max_nxt;
    logic             accept;
    logic             is_err;
    logic             frame_end;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && (v < FULL)) ? v + CNT_W'(1) : v;
    endfunction

    assign smp.in_ready = (state == COUNT);
    assign busy         = (state != IDLE);

    always_comb begin
        is_err    = (smp.even == smp.odd);
        accept    = smp.in_valid && (state == COUNT);
        frame_end = accept && (sample_cnt == LAST);
        even_nxt  = sat_inc(even_cnt, smp.even & ~smp.odd);
        odd_nxt   = sat_inc(odd_cnt, smp.odd & ~smp.even);
        err_nxt   = sat_inc(err_cnt, is_err);
        // run_len is nonzero exactly when the previous accepted sample in this
        // frame was legal, so it doubles as the "previous legal" flag.
        if (is_err) begin
            run_nxt = '0;
        end else if ((run_len != '0) && (smp.odd == last_par)) begin
            run_nxt = sat_inc(run_len, 1'b1);
        end else begin
            run_nxt = CNT_W'(1);
        end
        max_nxt = (run_nxt > max_run_int) ? run_nxt : max_run_int;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COUNT;
            COUNT:   if (frame_end) state_nxt = REPORT;
            REPORT:  state_nxt = COUNT;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            even_cnt    <= '0;
            odd_cnt     <= '0;
            err_cnt     <= '0;
            run_len     <= '0;
            max_run_int <= '0;
            last_par    <= 1'b0;
            even_count  <= '0;
            odd_count   <= '0;
            err_count   <= '0;
            max_run     <= '0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            if (clear) begin
                sample_cnt  <= '0;
                even_cnt    <= '0;
                odd_cnt     <= '0;
                err_cnt     <= '0;
                run_len     <= '0;
                max_run_int <= '0;
                last_par    <= 1'b0;
            end else if (frame_end) begin
                even_count  <= even_nxt;
                odd_count   <= odd_nxt;
                err_count   <= err_nxt;
                max_run     <= max_nxt;
                frame_done  <= 1'b1;
                sample_cnt  <= '0;
                even_cnt    <= '0;
                odd_cnt     <= '0;
                err_cnt     <= '0;
                run_len     <= '0;
                max_run_int <= '0;
                last_par    <= 1'b0;
            end else if (accept) begin
                sample_cnt  <= sample_cnt + CNT_W'(1);
                even_cnt    <= even_nxt;
                odd_cnt     <= odd_nxt;
                err_cnt     <= err_nxt;
                run_len     <= run_nxt;
                max_run_int <= max_nxt;
                last_par    <= smp.odd;
            end
        end
    end

endmodule
